volcano_word_rx: RTL and testbench

//  Receiving end of the ASCII volcano-name byte stream: accepts one byte per valid cycle,

---
 rtl/volcano_word_rx.sv | 178 +++++++++++++++++
 tb/tb_volcano_word_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/volcano_word_rx.sv
// Byte-stream word receiver: splits space-delimited ASCII words, matches them
// against a fixed 7-entry volcano dictionary and tracks the expected word order.
module volcano_word_rx #(
    parameter int         MAX_LEN = 12,
    parameter logic [7:0] DELIM   = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       word_valid,
    output logic [2:0] word_id,
    output logic [4:0] word_len,
    output logic       word_ovf,
    output logic       seq_err,
    output logic [7:0] match_count
);

    typedef enum logic [1:0] {IDLE, WORD, OVF} state_t;

    // Dictionary text is right-justified in 80 bits; first character is the most significant byte.
    function automatic logic [79:0] dictStr(input int k);
        case (k)
            0:       dictStr = {8'h00, "Tajumulco"};
            1:       dictStr = {32'h0, "Tacana"};
            2:       dictStr = "Acatenango";
            3:       dictStr = {40'h0, "Fuego"};
            4:       dictStr = {40'h0, "Santa"};
            5:       dictStr = {40'h0, "Maria"};
            default: dictStr = {48'h0, "Agua"};
        endcase
    endfunction

    function automatic logic [4:0] dictLen(input int k);
        case (k)
            0:       dictLen = 5'd9;
            1:       dictLen = 5'd6;
            2:       dictLen = 5'd10;
            3:       dictLen = 5'd5;
            4:       dictLen = 5'd5;
            5:       dictLen = 5'd5;
            default: dictLen = 5'd4;
        endcase
    endfunction

    function automatic logic [7:0] dictChar(input int k, input logic [4:0] pos);
        logic [79:0] s;
        int          l;
        s = dictStr(k);
        l = int'(dictLen(k));
        dictChar = 8'h00;
        if (int'(pos) < l) dictChar = s[(l - 1 - int'(pos)) * 8 +: 8];
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  len_q, len_d;
    logic [6:0]  mask_q, mask_d;
    logic [2:0]  expId_q, expId_d;
    logic        wordValid_q, wordValid_d;
    logic [2:0]  wordId_q, wordId_d;
    logic [4:0]  wordLen_q, wordLen_d;
    logic        wordOvf_q, wordOvf_d;
    logic        seqErr_q, seqErr_d;
    logic [7:0]  matchCnt_q, matchCnt_d;

    logic        isChar, isTerm, doReport, reportOvf;
    logic [2:0]  hitId, nextExp;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mask_d      = mask_q;
        expId_d     = expId_q;
        wordValid_d = 1'b0;
        wordId_d    = wordId_q;
        wordLen_d   = wordLen_q;
        wordOvf_d   = wordOvf_q;
        seqErr_d    = seqErr_q;
        matchCnt_d  = matchCnt_q;
        doReport    = 1'b0;
        reportOvf   = 1'b0;
        hitId       = 3'd0;

        isChar = rx_valid && (rx_data != 8'h00) && (rx_data != DELIM);
        isTerm = rx_valid && (rx_data == DELIM);

        for (int k = 0; k < 7; k++) begin
            if (mask_q[k] && (len_q == dictLen(k))) hitId = 3'(k + 1);
        end
        nextExp = (hitId == 3'd7) ? 3'd1 : 3'(hitId + 3'd1);

        case (state_q)
            IDLE: begin
                if (isChar) begin
                    state_d = WORD;
                    len_d   = 5'd1;
                    for (int k = 0; k < 7; k++) mask_d[k] = (dictChar(k, 5'd0) == rx_data);
                end
            end
            WORD: begin
                if (isChar) begin
                    len_d = 5'(len_q + 5'd1);
                    if (int'(len_q) < MAX_LEN) begin
                        for (int k = 0; k < 7; k++) begin
                            if ((len_q >= dictLen(k)) || (dictChar(k, len_q) != rx_data))
                                mask_d[k] = 1'b0;
                        end
                    end else begin
                        state_d = OVF;
                        mask_d  = 7'h00;
                    end
                end else if (isTerm) begin
                    doReport = 1'b1;
                end
            end
            OVF: begin
                if (isChar) begin
                    if (len_q != 5'd31) len_d = 5'(len_q + 5'd1);
                    mask_d = 7'h00;
                end else if (isTerm) begin
                    doReport  = 1'b1;
                    reportOvf = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The word buffer is recycled on the reporting edge so back-to-back words lose no bytes.
        if (doReport) begin
            wordValid_d = 1'b1;
            wordId_d    = reportOvf ? 3'd0 : hitId;
            wordLen_d   = len_q;
            wordOvf_d   = reportOvf;
            state_d     = IDLE;
            len_d       = 5'd0;
            mask_d      = 7'h7F;
            if (!reportOvf && (hitId != 3'd0)) begin
                matchCnt_d = 8'(matchCnt_q + 8'd1);
                if (hitId != expId_q) seqErr_d = 1'b1;
                expId_d = nextExp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= 5'd0;
            mask_q      <= 7'h7F;
            expId_q     <= 3'd1;
            wordValid_q <= 1'b0;
            wordId_q    <= 3'd0;
            wordLen_q   <= 5'd0;
            wordOvf_q   <= 1'b0;
            seqErr_q    <= 1'b0;
            matchCnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mask_q      <= mask_d;
            expId_q     <= expId_d;
            wordValid_q <= wordValid_d;
            wordId_q    <= wordId_d;
            wordLen_q   <= wordLen_d;
            wordOvf_q   <= wordOvf_d;
            seqErr_q    <= seqErr_d;
            matchCnt_q  <= matchCnt_d;
        end
    end

    assign word_valid  = wordValid_q;
    assign word_id     = wordId_q;
    assign word_len    = wordLen_q;
    assign word_ovf    = wordOvf_q;
    assign seq_err     = seqErr_q;
    assign match_count = matchCnt_q;

endmodule

// File: tb/tb_volcano_word_rx.sv
// Self-checking bench for volcano_word_rx: directed and random byte streams
// compared against a string-level reference model of word matching.
module tb_volcano_word_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       word_valid;
    logic [2:0] word_id;
    logic [4:0] word_len;
    logic       word_ovf;
    logic       seq_err;
    logic [7:0] match_count;

    int checks = 0;
    int errors = 0;

    volcano_word_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .word_valid  (word_valid),
        .word_id     (word_id),
        .word_len    (word_len),
        .word_ovf    (word_ovf),
        .seq_err     (seq_err),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int len;
        int ovf;
        int cnt;
        int seq;
    } rep_t;

    string dict[7] = '{"Tajumulco", "Tacana", "Acatenango", "Fuego", "Santa", "Maria", "Agua"};
    string fullStream = "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

    rep_t expQ[$];
    byte  curWord[$];
    int   mCount, mSeq, mExp, lastId, lastLen, lastOvf;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model works on whole words: buffer characters, compare strings on the delimiter.
    function automatic void modelReset();
        curWord.delete();
        expQ.delete();
        mCount = 0; mSeq = 0; mExp = 1;
        lastId = 0; lastLen = 0; lastOvf = 0;
    endfunction

    function automatic void modelByte(input byte b);
        rep_t r;
        if (b == 8'h00) return;
        if (b != 8'h20) begin
            curWord.push_back(b);
            return;
        end
        if (curWord.size() == 0) return;
        r.len = (curWord.size() > 31) ? 31 : curWord.size();
        r.ovf = (curWord.size() > 12) ? 1 : 0;
        r.id  = 0;
        if (r.ovf == 0) begin
            for (int k = 0; k < 7; k++) begin
                if (curWord.size() == dict[k].len()) begin
                    bit eq = 1'b1;
                    for (int i = 0; i < curWord.size(); i++)
                        if (curWord[i] != dict[k].getc(i)) eq = 1'b0;
                    if (eq) r.id = k + 1;
                end
            end
        end
        if (r.id != 0) begin
            mCount = (mCount + 1) % 256;
            if (r.id != mExp) mSeq = 1;
            mExp = (r.id % 7) + 1;
        end
        r.cnt = mCount;
        r.seq = mSeq;
        lastId = r.id; lastLen = r.len; lastOvf = r.ovf;
        expQ.push_back(r);
        curWord.delete();
    endfunction

    // Every report pulse is matched against the oldest expected report.
    always @(posedge clk) begin
        rep_t r;
        #1;
        if (rst_n && word_valid) begin
            checks++;
            assert (expQ.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_pulse: observed id %0d len %0d expected no pulse", word_id, word_len);
            end
            if (expQ.size() > 0) begin
                r = expQ.pop_front();
                checkVal("pulse_id", 32'(word_id), r.id);
                checkVal("pulse_len", 32'(word_len), r.len);
                checkVal("pulse_ovf", 32'(word_ovf), r.ovf);
                checkVal("pulse_count", 32'(match_count), r.cnt);
                checkVal("pulse_seq", 32'(seq_err), r.seq);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        modelByte(b);
    endtask

    task automatic sendStr(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) applyStimulus(s.getc(i), gaps);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        checkVal("rst_valid", 32'(word_valid), 0);
        checkVal("rst_id", 32'(word_id), 0);
        checkVal("rst_len", 32'(word_len), 0);
        checkVal("rst_ovf", 32'(word_ovf), 0);
        checkVal("rst_seq", 32'(seq_err), 0);
        checkVal("rst_count", 32'(match_count), 0);
    endtask

    task automatic checkOutput(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkVal({tag, "_drain"}, 32'(expQ.size()), 0);
        checkVal({tag, "_count"}, 32'(match_count), 32'(mCount));
        checkVal({tag, "_seq"}, 32'(seq_err), 32'(mSeq));
        checkVal({tag, "_hold_id"}, 32'(word_id), 32'(lastId));
        checkVal({tag, "_hold_len"}, 32'(word_len), 32'(lastLen));
        checkVal({tag, "_hold_ovf"}, 32'(word_ovf), 32'(lastOvf));
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        doReset();

        // Full transmit-order stream at one byte per clock.
        sendStr(fullStream, 1'b0);
        checkOutput("t1");
        checkVal("t1_count_const", 32'(match_count), 7);
        checkVal("t1_seq_const", 32'(seq_err), 0);
        checkVal("t1_last_len_const", 32'(word_len), 4);

        // Same stream twice with padding and random valid gaps.
        doReset();
        sendStr(fullStream, 1'b1);
        for (int i = 0; i < 202; i++) applyStimulus(8'h00, 1'b1);
        sendStr(fullStream, 1'b1);
        checkOutput("t2");
        checkVal("t2_count_const", 32'(match_count), 14);

        // Near misses: extra character and wrong case.
        sendStr("Fuegos fuego ", 1'b0);
        checkOutput("t3");
        checkVal("t3_id_const", 32'(word_id), 0);

        // Overflowing word.
        sendStr("ABCDEFGHIJKLMNOP ", 1'b0);
        checkOutput("t4");
        checkVal("t4_ovf_const", 32'(word_ovf), 1);
        checkVal("t4_len_const", 32'(word_len), 16);

        // Extra delimiters and out-of-order words.
        doReset();
        sendStr("   Agua  Tacana ", 1'b0);
        checkOutput("t5");
        checkVal("t5_seq_const", 32'(seq_err), 1);

        // Reset mid-word discards the partial word.
        doReset();
        sendStr("Tajum", 1'b0);
        doReset();
        sendStr("Agua ", 1'b0);
        checkOutput("t6a");
        checkVal("t6a_id_const", 32'(word_id), 7);
        doReset();
        sendStr("Tajum", 1'b0);
        doReset();
        sendStr("Tajumulco ", 1'b0);
        checkOutput("t6b");
        checkVal("t6b_seq_const", 32'(seq_err), 0);

        // Random mix of dictionary words, garbage words, padding and long words.
        doReset();
        for (int w = 0; w < 60; w++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                sendStr(dict[$urandom_range(0, 6)], 1'b1);
            end else begin
                int n;
                n = $urandom_range(1, 36);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 9) == 0) applyStimulus(8'h00, 1'b1);
                    else applyStimulus(8'($urandom_range(0, 1) ? 8'h41 + $urandom_range(0, 25)
                                                               : 8'h61 + $urandom_range(0, 25)), 1'b1);
                end
            end
            applyStimulus(8'h20, 1'b1);
            if ($urandom_range(0, 3) == 0) applyStimulus(8'h20, 1'b0);
        end
        checkOutput("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
